dma_chan_sched: RTL
===================

# dma_chan_sched

Channel scheduler for the 4-channel DMA. It collects per-channel transfer requests and picks one with the combinational `rr_arbiter`, feeding back its own registered last-grant as `prev`. It holds that grant while the DMA engine runs the transfer, then acknowledges the channel. A watchdog aborts a transfer whose `done` never arrives.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum BUSY cycles per grant before abort; legal range 2..65535.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `dma_req`  in  4  per-channel request, level. A channel keeps it high until acked and drops it in the cycle after its ack.
- `dma_ack`  out  4  one-hot, one-cycle pulse: the transfer for that channel has finished or been aborted.
- `dma_err`  out  1  one-cycle pulse coincident with `dma_ack` when the grant ended by timeout.
- `start`  out  1  one-cycle pulse to the engine: begin a transfer on `chan_sel`.
- `chan_sel`  out  4  one-hot granted channel. Zero when idle.
- `chan_num`  out  2  binary index of `chan_sel`. Zero when idle.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  in  1  engine completion, one-cycle pulse. Sampled only in BUSY.

## Operation
- Registers: `state`, `cur` (4b one-hot), `prev` (4b, drives `rr_arbiter.prev`), `cnt` (watchdog, width `$clog2(TIMEOUT+1)`), `dma_ack`, `dma_err`.
- Effective requests: `reqs_eff = dma_req & ~dma_ack`. This masks the channel being acked this cycle, because its stale `req` is still high.
- `rr_arbiter` inputs are `reqs = reqs_eff` and `prev = prev`. Its output `next` is one-hot, or zero when `reqs_eff == 0`. When `prev == 0`, the lowest index wins. Otherwise the search starts at the index after the set bit of `prev` and wraps 3→0.
- IDLE:
  - If `reqs_eff != 0`, load `cur <= next` and `prev <= next`, then go to START.
  - Otherwise stay in IDLE.
- START:
  - `start = 1`.
  - Go to BUSY and set `cnt <= 0`.
  - `done` is ignored.
- BUSY:
  - If `done`: `dma_ack <= cur`, `dma_err <= 0`, go to IDLE.
  - Else if `cnt == TIMEOUT-1`: `dma_ack <= cur`, `dma_err <= 1`, go to IDLE.
  - Else `cnt <= cnt+1`.
  - If `done` and the timeout condition fall in the same cycle, `done` wins and there is no error.
- `dma_ack` and `dma_err` clear automatically the cycle after they are set.
- `cur` is held from START through the end of BUSY. `chan_sel` is `cur` when not in IDLE, else 0. `chan_num` is the binary encoding of `chan_sel`.
- A drop of `dma_req` on the granted channel during START or BUSY is ignored; the grant persists until done or timeout.
- Reset (any time, including mid-transfer):
  - `state`=IDLE; `prev`, `cur`, `cnt`, `dma_ack` = 0; `dma_err` = 0.
  - All outputs are 0.
  - No ack is issued for the interrupted transfer.
  - The first grant after reset goes to the lowest requesting index.

## Timing
- Request-to-start latency:
  - `reqs_eff` nonzero in IDLE at cycle N.
  - START at N+1: `start=1`, `chan_sel` valid, `busy=1`.
  - BUSY from N+2.
- `done` at BUSY cycle M gives `dma_ack`, IDLE, `busy=0` at M+1. A new arbitration can complete in that same cycle, so the next START is at M+2.
- Back-to-back grant period with `done` in the first BUSY cycle: 3 cycles (IDLE, START, BUSY).
- Timeout: the BUSY cycle with `cnt == TIMEOUT-1` without `done` is the last one. Ack and error appear the next cycle, TIMEOUT+1 cycles after `start`.

## Structure
- Package `dma_sched_pkg`:
  - `NCH = 4` (fixed; `rr_arbiter` is 4-bit).
  - State enum `{IDLE, START, BUSY}`.
  - Function `onehot2idx` (4→2).
- Sub-module: one `rr_arbiter` instance. All state lives in `dma_chan_sched`.

## Test plan
- Reset release, `dma_req=0001`:
  - `start` and `chan_sel=0001` one cycle later.
  - `done` 3 cycles after `start` gives `dma_ack=0001` the next cycle.
  - Channel drops `req`; the block then idles with all outputs 0.
- `dma_req=1111` held (each channel re-requests immediately), `done` in the first BUSY cycle: grants cycle 0,1,2,3,0,1 with a `start` every 3 cycles.
- `dma_req=0100` still high in the ack cycle, dropped the next cycle: exactly one grant to ch2 and no second `start`.
- TIMEOUT=8, `dma_req=0010`, `done` never asserted:
  - `dma_ack=0010` and `dma_err=1` nine cycles after `start`.
  - Then IDLE.
- TIMEOUT=8, `done` in the final BUSY cycle (`cnt==7`): `dma_ack` asserted, `dma_err=0`.
- `rst_n` low during BUSY on ch3:
  - Outputs go to 0 immediately and no ack is issued.
  - After release with `dma_req=1010`, ch1 is granted first.

Source files
------------

// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared types and helpers for the 4-channel DMA scheduler
package dma_sched_pkg;
  localparam int NCH = 4;
  typedef enum logic [1:0] {IDLE, START, BUSY} state_e;
  function automatic logic [1:0] onehot2idx(input logic [NCH-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/dma_chan_sched_arb.sv
// rr_arbiter: combinational 4-way round-robin pick starting after prev
module rr_arbiter
  import dma_sched_pkg::*;
(
  input  logic [NCH-1:0] reqs,
  input  logic [NCH-1:0] prev,
  output logic [NCH-1:0] next
);
  logic [1:0] base;
  logic [1:0] idx;
  always_comb begin
    base = (prev == '0) ? 2'd0 : onehot2idx(prev) + 2'd1;
    next = '0;
    idx  = '0;
    // descending scan so the smallest offset from base is the last writer
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = base + 2'(i);
      if (reqs[idx]) next = 4'b0001 << idx;
    end
  end
endmodule

// File: rtl/dma_chan_sched.sv
// dma_chan_sched: grants one DMA channel at a time, acks on done, aborts on watchdog timeout
module dma_chan_sched
  import dma_sched_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] dma_req,
  output logic [NCH-1:0] dma_ack,
  output logic           dma_err,
  output logic           start,
  output logic [NCH-1:0] chan_sel,
  output logic [1:0]     chan_num,
  output logic           busy,
  input  logic           done
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e         state_q, state_d;
  logic [NCH-1:0] cur_q, cur_d, prev_q, prev_d, ack_q, ack_d;
  logic [NCH-1:0] reqs_eff, next;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d, timeout;
  // the channel being acked still shows a stale request this cycle
  assign reqs_eff = dma_req & ~ack_q;
  assign timeout  = cnt_q == CW'(TIMEOUT - 1);
  rr_arbiter u_arb (
    .reqs(reqs_eff),
    .prev(prev_q),
    .next(next)
  );
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (reqs_eff != '0) begin
        cur_d   = next;
        prev_d  = next;
        state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: if (done || timeout) begin
        ack_d   = cur_q;
        err_d   = !done;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign start    = state_q == START;
  assign chan_sel = busy ? cur_q : '0;
  assign chan_num = onehot2idx(chan_sel);
  assign dma_ack  = ack_q;
  assign dma_err  = err_q;
endmodule
